// File: rtl/prga_decrypt.sv
// Purpose: RC4 PRGA stage; walks S memory, XORs keystream with ROM bytes into the decrypted RAM.
// Latency: 12 cycles per message byte, 12*MSG_LEN cycles from leaving IDLE to entering DONE.
// Backpressure: none; memories are single-cycle synchronous, start is only sampled in IDLE.
module prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [ADDR_W-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J,
        RD_F, CAP_F, WR_DEC, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

    state_t            state;
    logic [7:0]        i, j, si, sj, f, enc;
    logic [ADDR_W-1:0] k;
    // NEXT occupies two cycles so every byte fills a fixed 12-cycle slot.
    logic              next_hold;

    // The message index drives the ROM directly, so it is stable for the whole byte.
    assign rom_address = k;

    // Decrypted byte is only presented while the RAM write strobe is up.
    assign dec_data = dec_wren ? (f ^ enc) : 8'h00;

    // Sequencer: outputs are registered and loaded on entry to the state that uses them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            f           <= '0;
            enc         <= '0;
            next_hold   <= 1'b0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            dec_address <= '0;
            dec_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            s_wren   <= 1'b0;
            s_data   <= '0;
            dec_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        next_hold <= 1'b0;
                        busy      <= 1'b1;
                        state     <= INC_I;
                    end
                end
                INC_I: begin
                    i         <= i + 8'd1;
                    s_address <= i + 8'd1;
                    state     <= RD_I;
                end
                RD_I: state <= CAP_I;
                CAP_I: begin
                    si        <= s_q;
                    j         <= j + s_q;
                    s_address <= j + s_q;
                    state     <= RD_J;
                end
                RD_J: state <= CAP_J;
                CAP_J: begin
                    // s[j] goes straight into the s[i] write slot.
                    sj        <= s_q;
                    s_address <= i;
                    s_data    <= s_q;
                    s_wren    <= 1'b1;
                    state     <= WR_I;
                end
                WR_I: begin
                    s_address <= j;
                    s_data    <= si;
                    s_wren    <= 1'b1;
                    state     <= WR_J;
                end
                WR_J: begin
                    s_address <= si + sj;
                    state     <= RD_F;
                end
                RD_F: state <= CAP_F;
                CAP_F: begin
                    f           <= s_q;
                    enc         <= rom_q;
                    dec_address <= k;
                    dec_wren    <= 1'b1;
                    state       <= WR_DEC;
                end
                WR_DEC: begin
                    next_hold <= 1'b0;
                    state     <= NEXT;
                end
                NEXT: begin
                    if (!next_hold) begin
                        next_hold <= 1'b1;
                    end else begin
                        next_hold <= 1'b0;
                        if (k == LAST_K) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k     <= k + ADDR_W'(1);
                            state <= INC_I;
                        end
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Purpose: directed checks of prga_decrypt against behavioural S/ROM/RAM memories and an RC4 model.
// Latency: expects 12 cycles per byte, 384 busy cycles for a 32-byte message.
// Backpressure: none; memories respond one cycle after address sampling.
module tb_prga_decrypt;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] s_address, s_data, s_q;
    logic       s_wren;
    logic [4:0] rom_address, dec_address;
    logic [7:0] rom_q, dec_data;
    logic       dec_wren, busy, done;

    prga_decrypt dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .rom_address(rom_address), .rom_q(rom_q),
        .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] smem [256];
    logic [7:0] ld_img [256];
    logic       ld_en = 1'b0;
    logic [7:0] rom [N];
    logic [7:0] dec_got [N];
    logic [7:0] exp_dec [N];
    logic [7:0] ms [256];
    logic [4:0] last_dec_addr = '0;
    int dec_cnt = 0, busy_cycles = 0, wr_total = 0, both_cnt = 0;
    int errors = 0, checks = 0;

    // S memory with a bulk-load port used only while the DUT is idle.
    always @(posedge clk) begin
        if (ld_en) begin
            for (int a = 0; a < 256; a++) smem[a] <= ld_img[a];
        end else if (s_wren) begin
            smem[s_address] <= s_data;
        end
        s_q   <= smem[s_address];
        rom_q <= rom[rom_address];
    end

    // Decrypted RAM plus activity counters.
    always @(posedge clk) begin
        if (dec_wren) begin
            dec_got[dec_address] <= dec_data;
            last_dec_addr        <= dec_address;
            dec_cnt              <= dec_cnt + 1;
        end
        if (busy) busy_cycles <= busy_cycles + 1;
        if (s_wren || dec_wren) wr_total <= wr_total + 1;
        if (s_wren && dec_wren) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_s();
        @(negedge clk);
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic identity_img();
        for (int a = 0; a < 256; a++) ld_img[a] = 8'(a);
    endtask

    // Independent RC4 PRGA over a snapshot of the bench S memory.
    task automatic model();
        logic [7:0] mi, mj, t, tmp;
        for (int a = 0; a < 256; a++) ms[a] = smem[a];
        mi = 0;
        mj = 0;
        for (int n = 0; n < N; n++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
            t = ms[mi] + ms[mj];
            exp_dec[n] = ms[t] ^ rom[n];
        end
    endtask

    task automatic wait_dec(input int target, input string tag);
        int n;
        n = 0;
        while (dec_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (dec_cnt < target) chk({tag, "_timeout"}, 32'(dec_cnt), 32'(target));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_all(input string tag);
        int bad;
        bad = 0;
        for (int n = 0; n < N; n++) if (dec_got[n] !== exp_dec[n]) bad++;
        chk({tag, "_bytes_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int d0, b0, w0;
        logic [7:0] tmp;
        int r;

        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_swren", {31'd0, s_wren}, 32'd0);
        chk("rst_decwren", {31'd0, dec_wren}, 32'd0);
        chk("rst_outs", {s_address, s_data, 3'd0, dec_address, dec_data}, 32'd0);
        chk("rst_rom_addr", {27'd0, rom_address}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Identity S, enc[0]=A5, enc[1]=00
        identity_img();
        for (int n = 0; n < N; n++) rom[n] = 8'(n * 7 + 3);
        rom[0] = 8'hA5;
        rom[1] = 8'h00;
        load_s();
        repeat (3) @(negedge clk);
        chk("idle_hold_busy", {31'd0, busy}, 32'd0);
        model();
        d0 = dec_cnt;
        b0 = busy_cycles;
        start = 1'b1;
        wait_dec(d0 + 1, "id_b0");
        chk("id_b0_addr", {27'd0, last_dec_addr}, 32'd0);
        chk("id_b0_data", {24'd0, dec_got[0]}, 32'h0000_00A7);
        chk("id_b0_s1", {24'd0, smem[1]}, 32'd1);
        start = 1'b0;
        wait_dec(d0 + 2, "id_b1");
        chk("id_b1_addr", {27'd0, last_dec_addr}, 32'd1);
        chk("id_b1_data", {24'd0, dec_got[1]}, 32'h0000_0005);
        chk("id_b1_s2", {24'd0, smem[2]}, 32'd3);
        chk("id_b1_s3", {24'd0, smem[3]}, 32'd2);
        wait_done("id");
        chk("id_cycles", 32'(busy_cycles - b0), 32'd384);
        check_all("id");

        // Start toggling in DONE: no writes, done held
        w0 = wr_total;
        for (int c = 0; c < 20; c++) begin
            start = ~start;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_no_writes", 32'(wr_total - w0), 32'd0);
        chk("done_held", {30'd0, busy, done}, 32'd1);

        // Random permutation and random message
        do_reset();
        identity_img();
        for (int a = 255; a > 0; a--) begin
            r = $urandom_range(a, 0);
            tmp = ld_img[a]; ld_img[a] = ld_img[r]; ld_img[r] = tmp;
        end
        for (int n = 0; n < N; n++) rom[n] = 8'($urandom);
        load_s();
        model();
        b0 = busy_cycles;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("rnd");
        chk("rnd_cycles", 32'(busy_cycles - b0), 32'd384);
        check_all("rnd");

        // s[1]=FF: j wraps to FF and s[i]+s[j] wraps to 8 bits
        do_reset();
        identity_img();
        ld_img[1] = 8'hFF;
        ld_img[255] = 8'h01;
        for (int n = 0; n < N; n++) rom[n] = 8'(8'h3C ^ n);
        load_s();
        model();
        chk("wrap_model_b0", {24'd0, exp_dec[0]}, 32'h0000_003C);
        start = 1'b1;
        wait_done("wrap");
        start = 1'b0;
        check_all("wrap");

        // Abort during byte 10, then restart from k=0
        do_reset();
        identity_img();
        for (int n = 0; n < N; n++) rom[n] = 8'($urandom);
        load_s();
        d0 = dec_cnt;
        start = 1'b1;
        wait_dec(d0 + 10, "abort");
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_flags", {28'd0, busy, done, s_wren, dec_wren}, 32'd0);
        chk("abort_outs", {s_address, s_data, 3'd0, dec_address, dec_data}, 32'd0);
        chk("abort_rom_addr", {27'd0, rom_address}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model();
        d0 = dec_cnt;
        start = 1'b1;
        wait_dec(d0 + 1, "restart");
        chk("restart_addr", {27'd0, last_dec_addr}, 32'd0);
        wait_done("restart");
        start = 1'b0;
        check_all("restart");

        chk("never_both_wren", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
